// File: rtl/parking_pkg.sv
// parking_pkg: shared types and default constants for the parking gate arbiter.
//   gate_state_t : gate sequencing FSM states
//   lane_t       : which lane currently owns the gate
//   DEF_*        : default timeout and timer-width values
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPENING = 3'd1,
        PASS    = 3'd2,
        CLOSING = 3'd3,
        FAULT   = 3'd4
    } gate_state_t;

    typedef enum logic {
        ENTRY = 1'b0,
        EXIT  = 1'b1
    } lane_t;

    localparam int DEF_PASS_TIMEOUT = 1000;
    localparam int DEF_GATE_TIMEOUT = 255;
    localparam int DEF_TIMER_W      = 16;

    function automatic lane_t other_lane(input lane_t l);
        return (l == ENTRY) ? EXIT : ENTRY;
    endfunction

endpackage

// File: rtl/parking_timeout_timer.sv
// parking_timeout_timer: saturating cycle counter with a programmable limit.
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous clear (has priority over enable)
//   enable       : count one per cycle while high
//   limit        : expiry threshold; expired is high once count >= limit-1
//   expired      : combinational flag from the registered count
module parking_timeout_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    localparam logic [TIMER_W-1:0] CNT_MAX = '1;

    logic [TIMER_W-1:0] count;
    logic [TIMER_W:0]   count_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != CNT_MAX))
            count <= count + 1'b1;
    end

    // Compare count+1 against limit in one extra bit so a limit of 0
    // cannot underflow and the saturated maximum still compares correctly.
    assign count_p1 = {1'b0, count} + {{TIMER_W{1'b0}}, 1'b1};
    assign expired  = (count_p1 >= {1'b0, limit});

endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: arbitrates the entry and exit lanes for one shared
// barrier gate and sequences it open -> pass -> close with sensor handshakes
// and timeouts. Emits one-cycle count_inc/count_dec when a car is confirmed.
//   inputs : clk, reset_n (async, active low), entry_req, exit_req, lot_full,
//            lot_empty, gate_opened, gate_closed, car_passed, fault_clr
//   outputs: entry_grant, exit_grant (pulses), gate_open_cmd, count_inc,
//            count_dec (pulses), busy, fault -- all registered
// Build option: define EXIT_PRIORITY_EN for fixed exit-over-entry priority;
// otherwise simultaneous eligible requests are served round-robin.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT,
    parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
    parameter int TIMER_W      = DEF_TIMER_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic entry_req,
    input  logic exit_req,
    input  logic lot_full,
    input  logic lot_empty,
    input  logic gate_opened,
    input  logic gate_closed,
    input  logic car_passed,
    input  logic fault_clr,
    output logic entry_grant,
    output logic exit_grant,
    output logic gate_open_cmd,
    output logic count_inc,
    output logic count_dec,
    output logic busy,
    output logic fault
);

    localparam logic [TIMER_W-1:0] PASS_LIM = TIMER_W'(PASS_TIMEOUT);
    localparam logic [TIMER_W-1:0] GATE_LIM = TIMER_W'(GATE_TIMEOUT);

    gate_state_t state, next_state;
    lane_t       served_lane, next_lane;

    logic entry_ok, exit_ok;
    logic grant_e, grant_x, inc, dec;
    logic tmr_clear, tmr_enable, tmr_expired;
    logic [TIMER_W-1:0] tmr_limit;

    assign entry_ok = entry_req & ~lot_full;
    assign exit_ok  = exit_req  & ~lot_empty;

    // One timer shared by all timed states; the limit follows the state.
    assign tmr_limit  = (state == PASS) ? PASS_LIM : GATE_LIM;
    assign tmr_clear  = (next_state != state);
    assign tmr_enable = (state == OPENING) || (state == PASS) || (state == CLOSING);

    parking_timeout_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    always_comb begin
        next_state = state;
        next_lane  = served_lane;
        grant_e    = 1'b0;
        grant_x    = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        case (state)
            IDLE: begin
                if (entry_ok | exit_ok) begin
                    next_state = OPENING;
                    if (entry_ok & exit_ok) begin
`ifdef EXIT_PRIORITY_EN
                        next_lane = EXIT;
`else
                        next_lane = other_lane(served_lane);
`endif
                    end else if (entry_ok) begin
                        next_lane = ENTRY;
                    end else begin
                        next_lane = EXIT;
                    end
                    grant_e = (next_lane == ENTRY);
                    grant_x = (next_lane == EXIT);
                end
            end
            OPENING: begin
                if (gate_opened)
                    next_state = PASS;
                else if (tmr_expired)
                    next_state = FAULT;
            end
            PASS: begin
                // A confirmed car wins over a coincident timeout.
                if (car_passed) begin
                    next_state = CLOSING;
                    inc = (served_lane == ENTRY);
                    dec = (served_lane == EXIT);
                end else if (tmr_expired) begin
                    next_state = CLOSING;
                end
            end
            CLOSING: begin
                if (gate_closed)
                    next_state = IDLE;
                else if (tmr_expired)
                    next_state = FAULT;
            end
            FAULT: begin
                // Recovery goes through CLOSING so the gate must prove it is
                // down before another lane is served.
                if (fault_clr)
                    next_state = CLOSING;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            served_lane   <= EXIT;
            entry_grant   <= 1'b0;
            exit_grant    <= 1'b0;
            gate_open_cmd <= 1'b0;
            count_inc     <= 1'b0;
            count_dec     <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= next_state;
            served_lane   <= next_lane;
            entry_grant   <= grant_e;
            exit_grant    <= grant_x;
            gate_open_cmd <= (next_state == OPENING) || (next_state == PASS);
            count_inc     <= inc;
            count_dec     <= dec;
            busy          <= (next_state != IDLE);
            fault         <= (next_state == FAULT);
        end
    end

endmodule
